// File: rtl/score_bcd_accumulator.sv
// Six-digit packed-BCD score register fed by binary increments.
// Each increment is converted by double-dabble, then added one digit per cycle and committed at once.
module score_bcd_accumulator #(
    parameter int unsigned SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        add_valid,
    input  logic [7:0]  add_value,
    output logic        add_ready,
    output logic        add_done,
    output logic [23:0] points
);

    typedef enum logic [1:0] {StIdle, StConv, StAdd, StDone} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_dd;
    logic [23:0] r_work;
    logic        r_carry;
    logic [23:0] r_points;
    logic        r_add_done;

    logic [11:0] w_bcd_adj;
    logic [19:0] w_pre;
    logic [3:0]  w_inc_digit;
    logic [3:0]  w_score_digit;
    logic [4:0]  w_sum;
    logic [3:0]  w_digit;
    logic        w_carry;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_bcd_adj[4*i +: 4] = (r_dd[8 + 4*i +: 4] >= 4'd5) ? r_dd[8 + 4*i +: 4] + 4'd3
                                                               : r_dd[8 + 4*i +: 4];
        end
        w_pre = {w_bcd_adj, r_dd[7:0]};
    end

    // Increment has only three BCD digits; higher digits just propagate the carry.
    always_comb begin
        w_inc_digit   = 4'd0;
        w_score_digit = 4'd0;
        case (r_cnt)
            3'd0: begin w_inc_digit = r_dd[11:8];  w_score_digit = r_points[3:0];   end
            3'd1: begin w_inc_digit = r_dd[15:12]; w_score_digit = r_points[7:4];   end
            3'd2: begin w_inc_digit = r_dd[19:16]; w_score_digit = r_points[11:8];  end
            3'd3: w_score_digit = r_points[15:12];
            3'd4: w_score_digit = r_points[19:16];
            3'd5: w_score_digit = r_points[23:20];
            default: ;
        endcase
        w_sum   = {1'b0, w_score_digit} + {1'b0, w_inc_digit} + {4'd0, r_carry};
        w_carry = (w_sum >= 5'd10);
        w_digit = w_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_dd       <= 20'd0;
            r_work     <= 24'd0;
            r_carry    <= 1'b0;
            r_points   <= 24'd0;
            r_add_done <= 1'b0;
        end else if (clear) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_carry    <= 1'b0;
            r_points   <= 24'd0;
            r_add_done <= 1'b0;
        end else begin
            r_add_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (add_valid) begin
                        r_dd    <= {12'd0, add_value};
                        r_cnt   <= 3'd0;
                        r_state <= StConv;
                    end
                end
                StConv: begin
                    r_dd  <= w_pre << 1;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_cnt   <= 3'd0;
                        r_carry <= 1'b0;
                        r_state <= StAdd;
                    end
                end
                StAdd: begin
                    r_work[{r_cnt, 2'b00} +: 4] <= w_digit;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == 3'd5) begin
                        r_cnt   <= 3'd0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_points   <= (r_carry && (SAT_EN != 0)) ? 24'h999999 : r_work;
                    r_add_done <= 1'b1;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign add_ready = (r_state == StIdle) && !clear;
    assign add_done  = r_add_done;
    assign points    = r_points;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Bench for score_bcd_accumulator: saturating and wrapping instances share stimulus;
// expected scores come from an integer decimal model queued at acceptance.
module tb_score_bcd_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        add_valid;
    logic [7:0]  add_value;
    logic        add_ready, add_done, add_ready_w, add_done_w;
    logic [23:0] points, points_w;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_sat, m_wrap;
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;
    logic        prev_done;
    logic [23:0] saved;

    always #5 clk = ~clk;

    score_bcd_accumulator #(.SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_value(add_value),
        .add_ready(add_ready), .add_done(add_done), .points(points)
    );

    score_bcd_accumulator #(.SAT_EN(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid), .add_value(add_value),
        .add_ready(add_ready_w), .add_done(add_done_w), .points(points_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic is_bcd(input logic [23:0] p);
        for (int i = 0; i < 6; i++) if (p[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_exp(input int v);
        m_sat  = (m_sat + v > 999999) ? 999999 : m_sat + v;
        m_wrap = (m_wrap + v) % 1000000;
        exp_q.push_back({to_bcd(m_sat), to_bcd(m_wrap)});
    endtask

    task automatic flush_model();
        exp_q.delete();
        m_sat  = 0;
        m_wrap = 0;
    endtask

    // Called at a negedge; returns at the negedge where add_done is seen.
    task automatic do_add(input logic [7:0] v);
        int k;
        k = 0;
        while (!add_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!add_ready) begin
            check_eq("ready_timeout", 0, 1);
            return;
        end
        add_valid = 1'b1;
        add_value = v;
        push_exp(int'(v));
        @(posedge clk);
        #1 add_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!add_done && k < 40);
        if (!add_done) check_eq("done_timeout", 0, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        flush_model();
        check_eq("clear_points", points, 0);
    endtask

    // Scoreboard: every commit pops one expected pair.
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (add_done || add_done_w) check_eq("done_align", add_done_w, add_done);
                if (add_done) begin
                    check_eq("done_width", prev_done, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_done", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("points_sat", points, mon_e[47:24]);
                        check_eq("points_wrap", points_w, mon_e[23:0]);
                        check_eq("bcd_sat", is_bcd(points), 1);
                        check_eq("bcd_wrap", is_bcd(points_w), 1);
                    end
                end
                prev_done = add_done;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t1, t2;
        int v;
        rst = 1'b1; clear = 1'b0; add_valid = 1'b0; add_value = 8'd0;
        m_sat = 0; m_wrap = 0;
        #1;
        check_eq("rst_points", points, 0);
        check_eq("rst_done", add_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rst_ready", add_ready, 1);
        @(negedge clk);

        // Single add with cycle-exact handshake timing.
        add_valid = 1'b1; add_value = 8'd37; push_exp(37);
        @(posedge clk);
        #1 add_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_eq("busy_ready", add_ready, 0);
            check_eq("busy_done", add_done, 0);
            check_eq("busy_points", points, 0);
        end
        @(negedge clk);
        check_eq("commit_ready", add_ready, 1);
        check_eq("commit_done", add_done, 1);
        check_eq("commit_points", points, 24'h000037);
        @(negedge clk);
        check_eq("done_low", add_done, 0);

        // Asynchronous reset in the middle of conversion.
        add_valid = 1'b1; add_value = 8'd5; push_exp(5);
        @(posedge clk);
        #1 add_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_points", points, 0);
        check_eq("midrst_done", add_done, 0);
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("midrst_ready", add_ready, 1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (add_done) n++;
        end
        check_eq("midrst_no_done", n, 0);

        // Carry chains.
        do_add(8'd95);
        do_add(8'd7);
        check_eq("carry_102", points, 24'h000102);
        do_clear();
        for (int i = 0; i < 392; i++) do_add(8'd255);
        do_add(8'd35);
        check_eq("pre_99995", points, 24'h099995);
        do_add(8'd255);
        check_eq("carry_100250", points, 24'h100250);
        saved = points;
        do_add(8'd0);
        check_eq("add_zero", points, saved);

        // Random regression against the decimal model.
        for (int i = 0; i < 2000; i++) begin
            v = (i % 2 == 1) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
            do_add(8'(v));
        end

        // Climb to 999990, then saturation versus wrap.
        while (m_sat + 255 <= 999990) do_add(8'd255);
        if (m_sat < 999990) do_add(8'(999990 - m_sat));
        check_eq("top_sat", points, 24'h999990);
        check_eq("top_wrap", points_w, 24'h999990);
        do_add(8'd200);
        check_eq("sat_999999", points, 24'h999999);
        check_eq("wrap_190", points_w, 24'h000190);
        do_add(8'd1);
        check_eq("sat_plus1_done", add_done, 1);
        check_eq("sat_hold", points, 24'h999999);
        check_eq("wrap_191", points_w, 24'h000191);

        // Request held while busy: accepted at the first free edge.
        do_clear();
        add_valid = 1'b1; add_value = 8'd10; push_exp(10);
        @(posedge clk);
        #1 add_value = 8'd5; push_exp(5);
        n = 0; t1 = 0; t2 = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (add_done) begin
                if (n == 0) t1 = c; else t2 = c;
                n++;
            end
            if (n == 1 && c == t1 + 1) add_valid = 1'b0;
        end
        add_valid = 1'b0;
        check_eq("busy_two_dones", n, 2);
        check_eq("busy_spacing", t2 - t1, 16);
        check_eq("busy_points", points, 24'h000015);

        // Clear at E7 discards the in-flight add.
        add_valid = 1'b1; add_value = 8'd3; push_exp(3);
        @(posedge clk);
        #1 add_valid = 1'b0;
        repeat (7) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check_eq("e7_clear_points", points, 0);
        check_eq("e7_clear_done", add_done, 0);
        clear = 1'b0;
        flush_model();
        #1 check_eq("e7_clear_ready", add_ready, 1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (add_done) n++;
        end
        check_eq("e7_no_done", n, 0);
        check_eq("e7_points_hold", points, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
